// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter: locks a requester for a whole packet.
// Ports: clock/reset, request/last/weight in; grant/grant_valid/grant_idx/timeout out.
module wrr_packet_arbiter #(
    parameter int N         = 4,
    parameter int WW        = 4,
    parameter int MAX_BEATS = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           request,
    input  logic [N-1:0]           last,
    input  logic [N*WW-1:0]        weight,
    output logic [N-1:0]           grant,
    output logic                   grant_valid,
    output logic [$clog2(N)-1:0]   grant_idx,
    output logic                   timeout
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [WW-1:0] cnt, cnt_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [N-1:0]  grant_n;
    logic          valid_n;
    logic [IW-1:0] idx_n;
    logic          timeout_n;

    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic [WW-1:0] wsel;
    logic [WW:0]   c;
    logic [WW:0]   weff;
    logic          release_req;
    logic          expire;

    // Rotating search starting at ptr; first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && request[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = (cand == IW'(N - 1)) ? '0 : cand + IW'(1);
        end
    end

    always_comb begin
        wsel = '0;
        for (int i = 0; i < N; i++) begin
            if (win == IW'(i)) wsel = weight[i*WW +: WW];
        end
    end

    // One extra bit so cnt+1 can reach 2**WW without wrapping.
    always_comb begin
        c    = (win == ptr) ? ({1'b0, cnt} + (WW+1)'(1)) : (WW+1)'(1);
        weff = (wsel == '0) ? (WW+1)'(1) : {1'b0, wsel};
    end

    // Dropping request counts as an abort, same as an end-of-packet.
    assign release_req = !request[grant_idx] || last[grant_idx];
    assign expire      = (MAX_BEATS > 0) && (hold_cnt == HW'(MAX_BEATS));

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        hold_n    = hold_cnt;
        grant_n   = grant;
        valid_n   = grant_valid;
        idx_n     = grant_idx;
        timeout_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n      = LOCKED;
                    grant_n      = '0;
                    grant_n[win] = 1'b1;
                    valid_n      = 1'b1;
                    idx_n        = win;
                    hold_n       = HW'(1);
                    if (c >= weff) begin
                        ptr_n = (win == IW'(N - 1)) ? '0 : win + IW'(1);
                        cnt_n = '0;
                    end else begin
                        ptr_n = win;
                        cnt_n = c[WW-1:0];
                    end
                end
            end
            LOCKED: begin
                if (release_req || expire) begin
                    state_n   = IDLE;
                    grant_n   = '0;
                    valid_n   = 1'b0;
                    idx_n     = '0;
                    hold_n    = '0;
                    timeout_n = !release_req;
                end else if (hold_cnt != '1) begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            hold_cnt    <= hold_n;
            grant       <= grant_n;
            grant_valid <= valid_n;
            grant_idx   <= idx_n;
            timeout     <= timeout_n;
        end
    end

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Directed testbench for wrr_packet_arbiter (N=4, WW=4, MAX_BEATS=8).
// Ports: drives clock/reset/request/last/weight, checks all outputs.
module tb_wrr_packet_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  request;
    logic [3:0]  last;
    logic [15:0] weight;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    wrr_packet_arbiter #(.N(4), .WW(4), .MAX_BEATS(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .request     (request),
        .last        (last),
        .weight      (weight),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        request = '0;
        last    = '0;
        weight  = 16'h1111;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        request = 4'b1111;
        last    = 4'b1111;
        weight  = 16'h1111;
        step();
        n_cmp++;
        if ({grant, grant_valid, grant_idx, timeout} !== 8'b0) begin
            n_bad++;
            $display("FAIL reset_outs got %b %b %b %b expected all zero",
                     grant, grant_valid, grant_idx, timeout);
        end
        request = '0;
        reset   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({grant, grant_valid, grant_idx, timeout} !== 8'b0) begin
                n_bad++;
                $display("FAIL idle_outs[%0d] got %b %b expected zero",
                         i, grant, grant_valid);
            end
        end
        request = 4'b1111;
        step();
        n_cmp++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL first_from_0 got %b idx %0d expected 0001 idx 0",
                     grant, grant_idx);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg [9];
        logic [1:0] ei [9];
        eg = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001};
        ei = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
        do_reset();
        weight  = 16'h1111;
        request = 4'b1111;
        last    = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            step();
            n_cmp++;
            if (grant !== eg[i] || grant_idx !== ei[i] ||
                grant_valid !== (eg[i] != 4'b0)) begin
                n_bad++;
                $display("FAIL rr[%0d] got %b/%b/%0d expected %b/%b/%0d",
                         i, grant, grant_valid, grant_idx,
                         eg[i], (eg[i] != 4'b0), ei[i]);
            end
        end
    endtask

    task automatic test_weight();
        logic [3:0] eg [13];
        logic [1:0] ei [13];
        eg = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000,
               4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000,
               4'b0001};
        ei = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0,
               2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
        do_reset();
        weight  = 16'h1113;
        request = 4'b1111;
        last    = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            step();
            n_cmp++;
            if (grant !== eg[i] || grant_idx !== ei[i]) begin
                n_bad++;
                $display("FAIL wrr[%0d] got %b/%0d expected %b/%0d",
                         i, grant, grant_idx, eg[i], ei[i]);
            end
        end
    endtask

    task automatic test_long_packet();
        do_reset();
        request = 4'b0100;
        last    = 4'b0000;
        step();
        n_cmp++;
        if (grant !== 4'b0100) begin
            n_bad++;
            $display("FAIL long_first got %b expected 0100", grant);
        end
        request = 4'b1111;
        last    = 4'b1011;
        for (int i = 2; i <= 6; i++) begin
            step();
            n_cmp++;
            if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
                n_bad++;
                $display("FAIL long_hold[%0d] got %b expected 0100", i, grant);
            end
        end
        last = 4'b1111;
        step();
        n_cmp++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL long_bubble got %b expected 0000", grant);
        end
        step();
        n_cmp++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
            n_bad++;
            $display("FAIL long_next got %b/%0d expected 1000/3",
                     grant, grant_idx);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        request = 4'b0010;
        last    = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            step();
            n_cmp++;
            if (grant !== 4'b0010 || timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL to_hold[%0d] got %b/%b expected 0010/0",
                         i, grant, timeout);
            end
        end
        step();
        n_cmp++;
        if (grant !== 4'b0000 || timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL to_pulse got %b/%b expected 0000/1", grant, timeout);
        end
        step();
        n_cmp++;
        if (grant !== 4'b0010 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL to_regrant got %b/%b expected 0010/0",
                     grant, timeout);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        request = 4'b1000;
        last    = 4'b0000;
        step();
        step();
        n_cmp++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
            n_bad++;
            $display("FAIL rm_lock got %b/%0d expected 1000/3",
                     grant, grant_idx);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL rm_async got %b/%b/%0d expected 0000/0/0",
                     grant, grant_valid, grant_idx);
        end
        step();
        reset   = 1'b0;
        request = 4'b1001;
        last    = 4'b1001;
        step();
        n_cmp++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL rm_after got %b/%0d expected 0001/0",
                     grant, grant_idx);
        end
    endtask

    task automatic test_abort();
        do_reset();
        request = 4'b0010;
        last    = 4'b0000;
        step();
        step();
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_bad++;
            $display("FAIL ab_lock got %b expected 0010", grant);
        end
        request = 4'b1000;
        step();
        n_cmp++;
        if (grant !== 4'b0000 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL ab_bubble got %b/%b expected 0000/0",
                     grant, timeout);
        end
        step();
        n_cmp++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3 || grant_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ab_next got %b/%0d expected 1000/3",
                     grant, grant_idx);
        end
    endtask

    initial begin
        reset   = 1'b1;
        request = '0;
        last    = '0;
        weight  = 16'h1111;
        test_reset();
        test_round_robin();
        test_weight();
        test_long_packet();
        test_timeout();
        test_reset_mid();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wrr_packet_arbiter.md
WRR_PACKET_ARBITER -- requirements
Module: wrr_packet_arbiter

Parameters
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters (2..16).
REQ-002 The block SHALL have parameter WW, default 4, giving the per-requester weight width in bits.
REQ-003 The block SHALL have parameter MAX_BEATS, default 0, giving the lock timeout in cycles; 0 disables the timeout.

Interface
REQ-004 clock  input  1  Single clock; all state changes on its rising edge.
REQ-005 reset  input  1  Asynchronous, active-high reset.
REQ-006 request  input  N  Per-requester request, level; held for the whole packet.
REQ-007 last  input  N  Per-requester end-of-packet marker; qualified by request of the same index.
REQ-008 weight  input  N*WW  Packets per turn; requester i uses bits [i*WW +: WW]; value 0 is treated as 1.
REQ-009 grant  output  N  One-hot grant, registered; all zero when idle.
REQ-010 grant_valid  output  1  Registered; high exactly when grant is non-zero.
REQ-011 grant_idx  output  clog2(N)  Binary index of the granted requester; 0 when not valid.
REQ-012 timeout  output  1  One-cycle pulse when a lock is force-released.

Function
REQ-013 Internal state SHALL be: FSM {IDLE, LOCKED}; priority pointer ptr (clog2(N) bits); credit counter cnt (WW bits); beat counter hold_cnt.
REQ-014 Search order SHALL be ptr, ptr+1, ..., ptr+N-1, modulo N; the winner w is the first index in that order with request high.
REQ-015 In IDLE with any request high at edge t, the block SHALL set, at t+1: state LOCKED, grant = onehot(w), grant_valid = 1, grant_idx = w, hold_cnt = 1.
REQ-016 In IDLE with no request high, all outputs SHALL stay zero and ptr and cnt SHALL hold.
REQ-017 On each grant decision the block SHALL compute c = (w==ptr) ? cnt+1 : 1 and weff = max(weight[w], 1).
REQ-018 If c >= weff, the block SHALL set ptr = (w+1) mod N and cnt = 0; otherwise it SHALL set ptr = w and cnt = c.
REQ-019 cnt arithmetic SHALL be performed at WW+1 bits so that no wrap occurs.
REQ-020 In LOCKED, grant, grant_idx and grant_valid SHALL hold constant; changes on request or last of other indices SHALL be ignored.
REQ-021 In LOCKED, request[w] & last[w] sampled high SHALL release: the next cycle is IDLE with grant = 0. That IDLE cycle is a mandatory one-cycle bubble, so the earliest next grant is two cycles after the last beat.
REQ-022 In LOCKED, request[w] sampled low SHALL be treated as a release (abort), with the same timing as REQ-021.
REQ-023 If MAX_BEATS > 0 and hold_cnt == MAX_BEATS with no release, the block SHALL force-release to IDLE and pulse timeout high for that IDLE cycle.
REQ-024 Otherwise, in LOCKED, hold_cnt SHALL increment and saturate.
REQ-025 A forced release SHALL update ptr as a normal release; ptr was already advanced at grant time.
REQ-026 A weight change SHALL take effect at the next grant decision; a lock in progress SHALL be unaffected.
REQ-027 No more than one grant bit SHALL ever be high.

Reset
REQ-028 While reset is high, the block SHALL asynchronously force: state IDLE, ptr = 0, cnt = 0, hold_cnt = 0, grant = 0, grant_valid = 0, grant_idx = 0, timeout = 0.
REQ-029 Reset asserted mid-packet SHALL drop grant in the same cycle, without waiting for a clock edge.
REQ-030 After reset deasserts, the first arbitration SHALL start from index 0.

Verification (N=4, WW=4)
REQ-031 Weights all 1, request=1111, last=1111 held -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-032 weight[0]=3 with others 1, request=1111, last=1111 -> grants in order 0001, 0001, 0001, 0010, 0100, 1000, 0001, each separated by one zero cycle.
REQ-033 request[2] held with last[2]=0 for 5 cycles, then last[2]=1, with request=1011 on the others -> grant=0100 for 6 cycles, 0000, then 1000.
REQ-034 MAX_BEATS=8, request=0010, last=0 -> grant=0010 for 8 cycles, then grant=0000 with timeout=1 for one cycle, then grant=0010 again.
REQ-035 Reset asserted during a lock on index 3 -> grant=0000 immediately; after release, request=1001 -> grant=0001.
REQ-036 request[1] dropped mid-packet with request[3] high -> one zero cycle, then grant=1000 and grant_idx=3.
